// File: rtl/fsm_reed_tx_if.sv
// Byte-stream interface between the RS encoder output, the TX sequencer and the UART TX.
// The slave modport is the sequencer's view. The master modport is the surrounding logic's view.
interface fsm_reed_tx_if;
  logic [7:0] enc_data;
  logic       enc_valid;
  logic       tx_busy;
  logic [7:0] Tx_DATA;
  logic       Tx_VALID;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;
  logic       frame_done;

  modport slave (
    input  enc_data, enc_valid, tx_busy,
    output Tx_DATA, Tx_VALID, fifo_full, fifo_empty, overflow, frame_done
  );

  modport master (
    output enc_data, enc_valid, tx_busy,
    input  Tx_DATA, Tx_VALID, fifo_full, fifo_empty, overflow, frame_done
  );
endinterface

// File: rtl/fsm_reed_tx.sv
// Transmit sequencer: buffers encoder bytes in a FIFO and feeds them to the UART TX one at a time,
// re-pulsing Tx_VALID if no busy acknowledge arrives, and counting bytes per codeword.
module fsm_reed_tx #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned FRAME_LEN   = 255,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input logic          clk,
  input logic          reset,
  fsm_reed_tx_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_ACK  = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  localparam logic [CW-1:0] FullCnt     = CW'(DEPTH);
  localparam logic [TW-1:0] TimeoutLast = TW'(ACK_TIMEOUT - 1);
  localparam logic [7:0]    LastByte    = 8'(FRAME_LEN - 1);

  logic [1:0]    state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          overflow_q, overflow_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          push, pop;

  // A pop on the load edge frees a slot, so a full FIFO can still accept that cycle's byte.
  assign pop  = (state_q == IDLE) && !empty_q && !bus.tx_busy;
  assign push = bus.enc_valid && (!full_q || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (bus.enc_valid & full_q & ~pop);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    byte_cnt_d = byte_cnt_q;
    tmo_d      = tmo_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          data_d  = mem_q[rd_ptr_q];
          valid_d = 1'b1;
          tmo_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TimeoutLast) begin
          valid_d = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d = IDLE;
          if (byte_cnt_q == LastByte) begin
            done_d     = 1'b1;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      byte_cnt_q <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == FullCnt);
      empty_q    <= (count_d == '0);
      overflow_q <= overflow_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_q      <= tmo_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.enc_data;
  end

  assign bus.Tx_DATA    = data_q;
  assign bus.Tx_VALID   = valid_q;
  assign bus.fifo_full  = full_q;
  assign bus.fifo_empty = empty_q;
  assign bus.overflow   = overflow_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_fsm_reed_tx.sv
// Self-checking bench for fsm_reed_tx: directed scenarios plus a randomized stream checked
// against a queue-based transaction model with a behavioural UART responder.
module tb_fsm_reed_tx;
  localparam int unsigned DEPTH       = 16;
  localparam int unsigned FRAME_LEN   = 4;
  localparam int unsigned ACK_TIMEOUT = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  fsm_reed_tx_if bus ();

  fsm_reed_tx #(
    .DEPTH      (DEPTH),
    .FRAME_LEN  (FRAME_LEN),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit uart_en, uart_rand;
  int ack_dly  = 2;
  int hold_len = 10;
  int u_wait, u_hold, falls, fall_cyc;

  logic [7:0] got_q[$];
  int         vgap_q[$];
  int         vabs_q[$];
  int         vfall_q[$];
  int         fd_cnt, fd_bad;

  // UART model: busy rises some cycles after a Tx_VALID and stays high for a while.
  task automatic uart_tick();
    if (u_hold > 0) begin
      u_hold--;
      if (u_hold == 0) begin
        bus.tx_busy = 1'b0;
        falls++;
        fall_cyc = cyc;
      end
    end else if (u_wait > 0) begin
      u_wait--;
      if (u_wait == 0) begin
        bus.tx_busy = 1'b1;
        u_hold = uart_rand ? int'($urandom_range(1, 8)) : hold_len;
      end
    end else if (bus.Tx_VALID) begin
      u_wait = uart_rand ? int'($urandom_range(1, 4)) : ack_dly;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.Tx_VALID) begin
      got_q.push_back(bus.Tx_DATA);
      vgap_q.push_back(cyc - fall_cyc);
      vabs_q.push_back(cyc);
      vfall_q.push_back(falls);
    end
    if (bus.frame_done) begin
      fd_cnt++;
      if (falls == 0 || (falls % FRAME_LEN) != 0) fd_bad++;
    end
    if (uart_en) uart_tick();
  endtask

  task automatic clear_mon();
    got_q.delete();
    vgap_q.delete();
    vabs_q.delete();
    vfall_q.delete();
    falls    = 0;
    fall_cyc = cyc;
    fd_cnt   = 0;
    fd_bad   = 0;
  endtask

  task automatic do_reset();
    bus.enc_valid = 1'b0;
    bus.enc_data  = 8'h00;
    bus.tx_busy   = 1'b0;
    uart_en       = 1'b0;
    uart_rand     = 1'b0;
    u_wait        = 0;
    u_hold        = 0;
    reset         = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic push(input logic [7:0] d);
    bus.enc_valid = 1'b1;
    bus.enc_data  = d;
    step();
    bus.enc_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.enc_valid = 1'b0;
    bus.enc_data  = 8'h00;
    bus.tx_busy   = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.Tx_DATA !== 8'h00)
      begin errors++; $display("FAIL reset_data: got %h need 00", bus.Tx_DATA); end
    checks++; if (bus.Tx_VALID !== 1'b0)
      begin errors++; $display("FAIL reset_valid: got %b need 0", bus.Tx_VALID); end
    checks++; if (bus.fifo_full !== 1'b0 || bus.fifo_empty !== 1'b1) begin
      errors++; $display("FAIL reset_flags: full=%b empty=%b need 0 1", bus.fifo_full,
                         bus.fifo_empty);
    end
    checks++; if (bus.overflow !== 1'b0 || bus.frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_status: ovf=%b done=%b need 0 0", bus.overflow,
                         bus.frame_done);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    uart_en = 1'b1;
    push(8'hA5);
    checks++; if (bus.Tx_VALID !== 1'b0 || bus.fifo_empty !== 1'b0) begin
      errors++; $display("FAIL single_push: valid=%b empty=%b need 0 0", bus.Tx_VALID,
                         bus.fifo_empty);
    end
    step();
    checks++; if (bus.Tx_VALID !== 1'b1 || bus.Tx_DATA !== 8'hA5) begin
      errors++; $display("FAIL single_load: valid=%b data=%h need 1 a5", bus.Tx_VALID,
                         bus.Tx_DATA);
    end
    checks++; if (bus.fifo_empty !== 1'b1)
      begin errors++; $display("FAIL single_empty: got %b need 1", bus.fifo_empty); end
    step();
    checks++; if (bus.Tx_VALID !== 1'b0)
      begin errors++; $display("FAIL single_pulse: got %b need 0", bus.Tx_VALID); end
    repeat (30) step();
    checks++; if (got_q.size() != 1 || fd_cnt != 0 || falls != 1) begin
      errors++; $display("FAIL single_done: pulses=%0d frames=%0d falls=%0d need 1 0 1",
                         got_q.size(), fd_cnt, falls);
    end
  endtask

  task automatic test_frame();
    do_reset();
    uart_en = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(i + 1));
    for (int n = 0; n < 300 && falls < 4; n++) step();
    repeat (5) step();
    checks++; if (got_q.size() != 4)
      begin errors++; $display("FAIL frame_count: got %0d need 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        checks++; if (got_q[i] !== 8'(i + 1)) begin
          errors++; $display("FAIL frame_byte%0d: got %h need %h", i, got_q[i], 8'(i + 1));
        end
        checks++; if (vfall_q[i] != i) begin
          errors++; $display("FAIL frame_order%0d: falls before=%0d need %0d", i, vfall_q[i], i);
        end
        if (i > 0) begin
          checks++; if (vgap_q[i] != 2) begin
            errors++; $display("FAIL frame_gap%0d: got %0d need 2", i, vgap_q[i]);
          end
        end
      end
    end
    checks++; if (fd_cnt != 1 || fd_bad != 0) begin
      errors++; $display("FAIL frame_done: count=%0d misplaced=%0d need 1 0", fd_cnt, fd_bad);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 15; i++) push(8'h40 + 8'(i));
    checks++; if (bus.fifo_full !== 1'b0)
      begin errors++; $display("FAIL ovf_full15: got %b need 0", bus.fifo_full); end
    push(8'h4F);
    checks++; if (bus.fifo_full !== 1'b1 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_full16: full=%b ovf=%b need 1 0", bus.fifo_full,
                         bus.overflow);
    end
    push(8'hEE);
    checks++; if (bus.overflow !== 1'b1 || bus.fifo_full !== 1'b1) begin
      errors++; $display("FAIL ovf_set: ovf=%b full=%b need 1 1", bus.overflow, bus.fifo_full);
    end
    repeat (3) step();
    bus.tx_busy = 1'b0;
    uart_en     = 1'b1;
    for (int n = 0; n < 1500 && got_q.size() < 16; n++) step();
    repeat (40) step();
    checks++; if (got_q.size() != 16)
      begin errors++; $display("FAIL ovf_count: got %0d need 16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== 8'h40 + 8'(i)) begin
        errors++; $display("FAIL ovf_byte%0d: got %h need %h", i, got_q[i], 8'h40 + 8'(i));
      end
    end
    checks++; if (bus.overflow !== 1'b1 || bus.fifo_empty !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: ovf=%b empty=%b need 1 1", bus.overflow,
                         bus.fifo_empty);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    push(8'h3C);
    for (int n = 0; n < 400 && got_q.size() < 3; n++) step();
    checks++; if (got_q.size() != 3)
      begin errors++; $display("FAIL tmo_count: got %0d need 3", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== 8'h3C)
        begin errors++; $display("FAIL tmo_data%0d: got %h need 3c", i, got_q[i]); end
      if (i > 0) begin
        checks++; if (vabs_q[i] - vabs_q[i-1] != int'(ACK_TIMEOUT)) begin
          errors++; $display("FAIL tmo_period%0d: got %0d need %0d", i,
                             vabs_q[i] - vabs_q[i-1], ACK_TIMEOUT);
        end
      end
    end
    repeat (5) step();
    bus.tx_busy = 1'b1;
    repeat (3) step();
    bus.tx_busy = 1'b0;
    repeat (100) step();
    checks++; if (got_q.size() != 3 || bus.fifo_empty !== 1'b1 || bus.Tx_DATA !== 8'h3C) begin
      errors++; $display("FAIL tmo_ack: pulses=%0d empty=%b data=%h need 3 1 3c", got_q.size(),
                         bus.fifo_empty, bus.Tx_DATA);
    end
  endtask

  task automatic test_full_simul();
    do_reset();
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
    bus.tx_busy   = 1'b0;
    uart_en       = 1'b1;
    push(8'hEE);
    checks++; if (bus.fifo_full !== 1'b1 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL simul_flags: full=%b ovf=%b need 1 0", bus.fifo_full,
                         bus.overflow);
    end
    checks++; if (bus.Tx_VALID !== 1'b1 || bus.Tx_DATA !== 8'h60) begin
      errors++; $display("FAIL simul_load: valid=%b data=%h need 1 60", bus.Tx_VALID,
                         bus.Tx_DATA);
    end
    for (int n = 0; n < 1500 && got_q.size() < 17; n++) step();
    repeat (40) step();
    checks++; if (got_q.size() != 17)
      begin errors++; $display("FAIL simul_count: got %0d need 17", got_q.size()); end
    for (int i = 0; i < 17 && i < got_q.size(); i++) begin
      logic [7:0] exp;
      exp = (i < 16) ? 8'h60 + 8'(i) : 8'hEE;
      checks++; if (got_q[i] !== exp)
        begin errors++; $display("FAIL simul_byte%0d: got %h need %h", i, got_q[i], exp); end
    end
    checks++; if (bus.overflow !== 1'b0 || bus.fifo_empty !== 1'b1) begin
      errors++; $display("FAIL simul_end: ovf=%b empty=%b need 0 1", bus.overflow,
                         bus.fifo_empty);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    uart_en = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h80 + 8'(i));
    for (int n = 0; n < 20 && bus.tx_busy !== 1'b1; n++) step();
    checks++; if (bus.fifo_empty !== 1'b0 || bus.Tx_DATA !== 8'h80) begin
      errors++; $display("FAIL rmid_pre: empty=%b data=%h need 0 80", bus.fifo_empty,
                         bus.Tx_DATA);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.Tx_DATA !== 8'h00 || bus.Tx_VALID !== 1'b0)
      begin errors++; $display("FAIL rmid_out: data=%h valid=%b need 00 0", bus.Tx_DATA,
                               bus.Tx_VALID); end
    checks++; if (bus.fifo_empty !== 1'b1 || bus.fifo_full !== 1'b0 || bus.overflow !== 1'b0 ||
                  bus.frame_done !== 1'b0) begin
      errors++; $display("FAIL rmid_flags: empty=%b full=%b ovf=%b done=%b need 1 0 0 0",
                         bus.fifo_empty, bus.fifo_full, bus.overflow, bus.frame_done);
    end
    uart_en     = 1'b0;
    u_wait      = 0;
    u_hold      = 0;
    bus.tx_busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    repeat (50) step();
    checks++; if (got_q.size() != 0 || bus.fifo_empty !== 1'b1) begin
      errors++; $display("FAIL rmid_after: pulses=%0d empty=%b need 0 1", got_q.size(),
                         bus.fifo_empty);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    do_reset();
    uart_en   = 1'b1;
    uart_rand = 1'b1;
    for (int b = 0; b < 3; b++) begin
      int n;
      n = int'($urandom_range(5, DEPTH));
      for (int j = 0; j < n; j++) begin
        logic [7:0] d;
        repeat ($urandom_range(0, 2)) step();
        d = 8'($urandom);
        exp_q.push_back(d);
        push(d);
      end
      for (int k = 0; k < 1000 && got_q.size() < exp_q.size(); k++) step();
    end
    repeat (20) step();
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i])
        begin errors++; $display("FAIL rand_byte%0d: got %h need %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (fd_cnt != exp_q.size() / FRAME_LEN || fd_bad != 0) begin
      errors++; $display("FAIL rand_frames: count=%0d misplaced=%0d need %0d 0", fd_cnt, fd_bad,
                         exp_q.size() / FRAME_LEN);
    end
    checks++; if (bus.overflow !== 1'b0 || bus.fifo_empty !== 1'b1) begin
      errors++; $display("FAIL rand_end: ovf=%b empty=%b need 0 1", bus.overflow,
                         bus.fifo_empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame();
    test_overflow();
    test_timeout();
    test_full_simul();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fsm_reed_tx.md
Name: fsm_reed_tx

Overview:
- Transmit-side sequencer for the Reed-Solomon datapath.
- Accepts codeword bytes from the encoder output, buffers them in a small FIFO, and hands them one at a time to the UART transmitter using a valid-pulse / busy handshake.
- Counts bytes per codeword and flags frame completion and buffer overflow.
- Sits between the RS encoder output stage and the UART TX.

Parameters:
- DEPTH, 16, FIFO depth in bytes; power of two, minimum 2.
- FRAME_LEN, 255, bytes per codeword; range 1..256.
- ACK_TIMEOUT, 64, cycles to wait for tx_busy to rise before re-pulsing Tx_VALID; minimum 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enc_data  in  8  codeword byte from the encoder.
- enc_valid  in  1  enc_data is valid this cycle; push request, one byte per cycle.
- tx_busy  in  1  UART TX is shifting a byte; the rising edge is the acknowledge.
- Tx_DATA  out  8  byte presented to the UART TX; held stable from load until the next load.
- Tx_VALID  out  1  single-cycle start pulse to the UART TX.
- fifo_full  out  1  FIFO holds DEPTH bytes.
- fifo_empty  out  1  FIFO holds 0 bytes.
- overflow  out  1  sticky; set when a push is attempted while full.
- frame_done  out  1  one-cycle pulse when the last byte of a codeword completes transmission.

Behaviour:
- Reset (async, any state): state=IDLE, FIFO pointers and count=0.
  - Outputs: Tx_DATA=0, Tx_VALID=0, fifo_full=0, fifo_empty=1, overflow=0, frame_done=0.
  - Byte counter=0 and timeout counter=0.
  - A reset mid-frame discards buffered bytes and the partial frame count.
- FIFO:
  - Push when enc_valid=1 and not full.
  - When full, enc_valid=1 drops the byte and sets overflow, which stays set until reset.
  - Pop occurs only on the IDLE->WAIT_ACK load edge.
  - Simultaneous push and pop: count unchanged, both pointers advance. This is allowed even when full; the pop frees the slot and the push is accepted.
  - Pointers wrap modulo DEPTH. fifo_full and fifo_empty are registered and derived from count.
- FSM states: IDLE, WAIT_ACK, WAIT_DONE.
  - IDLE:
    - If FIFO is non-empty and tx_busy=0: at the edge, Tx_DATA<=head, Tx_VALID<=1, pop, timeout<=0, go to WAIT_ACK.
    - Otherwise stay in IDLE.
  - WAIT_ACK:
    - Tx_VALID is high only in the first cycle after the load (single pulse).
    - If tx_busy=1, go to WAIT_DONE.
    - Else the timeout counter increments. On reaching ACK_TIMEOUT-1, re-pulse Tx_VALID for one cycle with the same Tx_DATA, reset the timeout counter, and stay in WAIT_ACK. There is no retry limit.
  - WAIT_DONE:
    - When tx_busy=0, go to IDLE and increment the byte counter.
    - If the byte counter was FRAME_LEN-1, pulse frame_done for that cycle and wrap the counter to 0.
- Latency:
  - A byte pushed at edge k into an empty FIFO while IDLE with tx_busy=0 produces Tx_VALID=1 after edge k+1.
  - Back-to-back bytes: minimum spacing is 1 idle cycle after tx_busy falls.
- A tx_busy level that is already high in IDLE blocks loading; the FSM waits for it to go low.
- A tx_busy glitch during WAIT_DONE (high→low→high) ends the byte at the first low.
- Byte counter width is 8 bits; FRAME_LEN=256 wraps naturally at 255.

Test Plan:
- Reset, then push 0xA5 with tx_busy model (rises 2 cycles after Tx_VALID, high 10 cycles) -> Tx_VALID single pulse 1 cycle after push, Tx_DATA=0xA5, fifo_empty returns to 1, no frame_done (FRAME_LEN=255).
- FRAME_LEN=4: push 0x01..0x04 back-to-back -> four Tx_VALID pulses in order 01,02,03,04, each after the previous tx_busy falls; frame_done pulses once, after byte 0x04's tx_busy falls.
- DEPTH=16, tx_busy held high: push 17 bytes -> fifo_full=1 after the 16th, 17th byte dropped, overflow=1 and sticky. Release tx_busy -> exactly the first 16 bytes are transmitted in order.
- No ack (tx_busy stuck 0), ACK_TIMEOUT=64 -> Tx_VALID re-pulses every 64 cycles with the same Tx_DATA. Raising tx_busy then completes the byte normally.
- Full FIFO with simultaneous enc_valid on the IDLE load edge -> count stays 16, the new byte is accepted, overflow stays 0.
- Assert reset asynchronously during WAIT_DONE with 5 bytes buffered -> all outputs go to reset values immediately (mid-cycle), fifo_empty=1, and no Tx_VALID follows after release.
